// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and the fixed
// constants used by the PC sequencer and the IF/ID register.
package fetch_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    DS_WAIT = 1'b1
  } fetchState_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC and a valid
// flag. Stall holds every field; flush (lower priority than stall) loads a
// bubble: NOP instruction, the supplied PC, valid cleared.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall             hold all fields
//   flush             load a bubble instead of instrIn
//   instrIn, pcIn     instruction/PC to capture
//   instr, pc, valid  registered IF/ID contents
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [width-1:0] instrIn,
  input  logic [width-1:0] pcIn,
  output logic [width-1:0] instr,
  output logic [width-1:0] pc,
  output logic             valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (!stall) begin
      pc <= pcIn;
      if (flush) begin
        instr <= width'(NOP_INSTR);
        valid <= 1'b0;
      end else begin
        instr <= instrIn;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// Fetch-stage PC sequencer plus IF/ID register. Owns the fetch PC, issues the
// instruction-memory request and applies taken branch/jump redirects coming
// back from decode.
// Configuration macro: FETCH_DELAY_SLOT_EN
//   undefined - a redirect squashes the wrong-path instruction (one bubble)
//   defined   - the instruction after a branch/jump executes as a delay slot;
//               if it is not yet available the target is parked in DS_WAIT
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   stall_F, stall_D      hazard-unit holds for fetch and IF/ID
//   realBJ_D, targetPC_D  decode-stage taken branch/jump and its target
//   imem_req, imem_addr   instruction-memory request (addr = pc_F)
//   imem_ready, imem_rdata instruction-memory response
//   pc_F                  current fetch PC
//   instr_D, pc_D, valid_D IF/ID contents
module fetch_redirect
  import fetch_pkg::*;
#(
  parameter int unsigned            width    = 32,
  parameter logic [width-1:0]       RESET_PC = width'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_F,
  input  logic             stall_D,
  input  logic             realBJ_D,
  input  logic [width-1:0] targetPC_D,
  output logic             imem_req,
  output logic [width-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [width-1:0] imem_rdata,
  output logic [width-1:0] pc_F,
  output logic [width-1:0] instr_D,
  output logic [width-1:0] pc_D,
  output logic             valid_D
);

  logic             accept;
  logic             redirect;
  logic             flushD;
  logic [width-1:0] pcInc;
  logic [width-1:0] pcNext;

  assign imem_req  = ~stall_F;
  assign imem_addr = pc_F;
  assign accept    = imem_req & imem_ready & ~stall_D;
  assign pcInc     = pc_F + width'(PC_INC);

`ifdef FETCH_DELAY_SLOT_EN
  fetchState_t      state, stateNext;
  logic [width-1:0] pendPc, pendPcNext;

  // A redirect whose delay slot is not yet fetched parks the target in
  // pendPc; the delay slot is fetched from the held pc_F first.
  always_comb begin
    stateNext  = state;
    pendPcNext = pendPc;
    pcNext     = pc_F;
    redirect   = 1'b0;
    flushD     = ~accept;
    case (state)
      RUN: begin
        redirect = realBJ_D & valid_D & ~stall_D;
        if (redirect) begin
          if (accept) begin
            pcNext = targetPC_D;
          end else begin
            pendPcNext = targetPC_D;
            stateNext  = DS_WAIT;
          end
        end else if (accept) begin
          pcNext = pcInc;
        end
      end
      DS_WAIT: begin
        if (accept) begin
          pcNext    = pendPc;
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      pendPc <= '0;
    end else begin
      state  <= stateNext;
      pendPc <= pendPcNext;
    end
  end
`else
  // Redirect takes priority over stall_F so a resolved branch is never lost:
  // the IF/ID bubble it inserts would otherwise drop valid_D and the branch.
  always_comb begin
    redirect = realBJ_D & valid_D & ~stall_D;
    flushD   = ~accept | redirect;
    if (redirect)    pcNext = targetPC_D;
    else if (accept) pcNext = pcInc;
    else             pcNext = pc_F;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_F <= RESET_PC;
    else     pc_F <= pcNext;
  end

  if_id_reg #(
    .width (width)
  ) u_ifId (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall_D),
    .flush   (flushD),
    .instrIn (imem_rdata),
    .pcIn    (pc_F),
    .instr   (instr_D),
    .pc      (pc_D),
    .valid   (valid_D)
  );

endmodule

// File: tb/tb_fetch_redirect.sv
module tb_fetch_redirect;

  logic        clk;
  logic        rst;
  logic        stall_F;
  logic        stall_D;
  logic        realBJ_D;
  logic [31:0] targetPC_D;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic        valid_D;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_redirect #(
    .width    (32),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .realBJ_D   (realBJ_D),
    .targetPC_D (targetPC_D),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_F       (pc_F),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .valid_D    (valid_D)
  );

  // Instruction memory model: each word is its address tagged with a pattern.
  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = instrOf(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IF/ID expectation: a valid entry carries the memory word of its PC, a
  // bubble carries NOP.
  task automatic checkD(input string tag, input logic [31:0] pcExp, input logic validExp);
    checkVal({tag, ".pc_D"}, pc_D, pcExp);
    checkVal({tag, ".valid_D"}, {31'b0, valid_D}, {31'b0, validExp});
    checkVal({tag, ".instr_D"}, instr_D, validExp ? instrOf(pcExp) : 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    realBJ_D   = 1'b0;
    targetPC_D = 32'h0;
    imem_ready = 1'b1;

    // Reset state held across clock edges
    step();
    step();
    checkVal("rst.pc_F", pc_F, 32'h0040_0000);
    checkD("rst", 32'h0, 1'b0);
    rst = 1'b0;

    // Sequential fetch from RESET_PC
    checkVal("seq0.addr", imem_addr, 32'h0040_0000);
    checkVal("seq0.req", {31'b0, imem_req}, 32'd1);
    step();
    checkVal("seq1.addr", imem_addr, 32'h0040_0004);
    checkD("seq1", 32'h0040_0000, 1'b1);
    step();
    checkVal("seq2.addr", imem_addr, 32'h0040_0008);
    checkD("seq2", 32'h0040_0004, 1'b1);

    // Taken branch while decoding 0x400004
    realBJ_D   = 1'b1;
    targetPC_D = 32'h0040_0100;
    step();
    realBJ_D = 1'b0;
    checkVal("br.pc_F", pc_F, 32'h0040_0100);
`ifdef FETCH_DELAY_SLOT_EN
    checkD("br.slot", 32'h0040_0008, 1'b1);
`else
    checkD("br.squash", 32'h0040_0008, 1'b0);
`endif
    step();
    checkVal("br1.pc_F", pc_F, 32'h0040_0104);
    checkD("br1", 32'h0040_0100, 1'b1);

    // Jump to 0x400010, then memory not ready for two cycles
    realBJ_D   = 1'b1;
    targetPC_D = 32'h0040_0010;
    step();
    realBJ_D   = 1'b0;
    checkVal("jmp.pc_F", pc_F, 32'h0040_0010);
    imem_ready = 1'b0;
    step();
    checkVal("nr1.pc_F", pc_F, 32'h0040_0010);
    checkVal("nr1.valid_D", {31'b0, valid_D}, 32'd0);
    step();
    checkVal("nr2.pc_F", pc_F, 32'h0040_0010);
    checkVal("nr2.valid_D", {31'b0, valid_D}, 32'd0);
    imem_ready = 1'b1;
    step();
    checkVal("nr3.pc_F", pc_F, 32'h0040_0014);
    checkD("nr3", 32'h0040_0010, 1'b1);

    // stall_D blocks redirect and accept; redirect on first unstalled cycle
    stall_D    = 1'b1;
    realBJ_D   = 1'b1;
    targetPC_D = 32'h0040_0300;
    step();
    checkVal("sd1.pc_F", pc_F, 32'h0040_0014);
    checkD("sd1", 32'h0040_0010, 1'b1);
    step();
    checkVal("sd2.pc_F", pc_F, 32'h0040_0014);
    checkD("sd2", 32'h0040_0010, 1'b1);
    stall_D = 1'b0;
    step();
    realBJ_D = 1'b0;
    checkVal("sd3.pc_F", pc_F, 32'h0040_0300);
`ifdef FETCH_DELAY_SLOT_EN
    checkD("sd3", 32'h0040_0014, 1'b1);
`else
    checkD("sd3", 32'h0040_0014, 1'b0);
`endif

    // stall_F: no request, pc_F holds, nothing accepted
    stall_F = 1'b1;
    #1;
    checkVal("sf.req", {31'b0, imem_req}, 32'd0);
    step();
    stall_F = 1'b0;
    checkVal("sf.pc_F", pc_F, 32'h0040_0300);
    checkVal("sf.valid_D", {31'b0, valid_D}, 32'd0);
    step();
    checkVal("sf1.pc_F", pc_F, 32'h0040_0304);
    checkD("sf1", 32'h0040_0300, 1'b1);

    // PC wrap at the top of the address space
    realBJ_D   = 1'b1;
    targetPC_D = 32'hFFFF_FFFC;
    step();
    realBJ_D = 1'b0;
    checkVal("wrap0.pc_F", pc_F, 32'hFFFF_FFFC);
    step();
    checkVal("wrap1.pc_F", pc_F, 32'h0000_0000);
    checkD("wrap1", 32'hFFFF_FFFC, 1'b1);
    step();
    checkVal("wrap2.pc_F", pc_F, 32'h0000_0004);
    checkD("wrap2", 32'h0000_0000, 1'b1);

`ifdef FETCH_DELAY_SLOT_EN
    // Redirect without accept parks target; delay slot fetched on ready
    realBJ_D   = 1'b1;
    targetPC_D = 32'h0040_0200;
    imem_ready = 1'b0;
    step();
    realBJ_D = 1'b0;
    checkVal("dsw1.pc_F", pc_F, 32'h0000_0004);
    checkVal("dsw1.valid_D", {31'b0, valid_D}, 32'd0);
    step();
    step();
    checkVal("dsw3.pc_F", pc_F, 32'h0000_0004);
    imem_ready = 1'b1;
    step();
    checkVal("dsw4.pc_F", pc_F, 32'h0040_0200);
    checkD("dsw4", 32'h0000_0004, 1'b1);
    step();
    checkD("dsw5", 32'h0040_0200, 1'b1);

    // Reset during DS_WAIT drops the pending target
    realBJ_D   = 1'b1;
    targetPC_D = 32'h0040_0600;
    imem_ready = 1'b0;
    step();
    realBJ_D = 1'b0;
    checkVal("dsr.pc_F", pc_F, 32'h0040_0204);
`else
    imem_ready = 1'b0;
`endif
    rst = 1'b1;
    #1;
    checkVal("arst.pc_F", pc_F, 32'h0040_0000);
    checkD("arst", 32'h0, 1'b0);
    step();
    rst        = 1'b0;
    imem_ready = 1'b1;
    step();
    checkVal("post.pc_F", pc_F, 32'h0040_0004);
    checkD("post", 32'h0040_0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
